// File: rtl/phase_seq_monitor.sv
// phase_seq_monitor: observer for a free-running 3-phase sequencer (0->1->2->0).
// Tracks lock, counts completed rounds (wrapping) and sequence violations
// (saturating), and registers a one-hot decode of the last valid phase sample.
// Optional build macro: PHASE_SEQ_HOLD_ALLOW_EN -- when defined, a repeat of the
// last accepted phase while locked is treated as a hold instead of a violation.
module phase_seq_monitor #(
  parameter int unsigned ROUND_W = 8,
  parameter int unsigned ERR_W   = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  input  logic [1:0]         phase_in,
  input  logic               clr_err,
  output logic [2:0]         phase_oh,
  output logic               locked,
  output logic               round_done,
  output logic [ROUND_W-1:0] round_cnt,
  output logic               err,
  output logic [ERR_W-1:0]   err_cnt
);

  typedef enum logic {HUNT, LOCK} state_t;

  state_t       state, state_next;
  logic [1:0]   expected, expected_next;
  logic         violation, round_hit, hold;

  logic [2:0]         oh_next;
  logic               round_done_next;
  logic [ROUND_W-1:0] round_cnt_next;
  logic               err_next;
  logic [ERR_W-1:0]   err_cnt_next;

  // Legal successor of a phase; 3 has none and maps to 0 (never used as expected).
  function automatic logic [1:0] succ(input logic [1:0] p);
    if (p == 2'd0)      return 2'd1;
    else if (p == 2'd1) return 2'd2;
    else if (p == 2'd2) return 2'd0;
    else                return 2'd0;
  endfunction

`ifdef PHASE_SEQ_HOLD_ALLOW_EN
  // Last accepted phase is the predecessor of the expected one.
  function automatic logic [1:0] pred(input logic [1:0] p);
    if (p == 2'd1)      return 2'd0;
    else if (p == 2'd2) return 2'd1;
    else                return 2'd2;
  endfunction

  assign hold = in_valid && (state == LOCK) && (phase_in == pred(expected));
`else
  assign hold = 1'b0;
`endif

  // State register: lock state and expected next phase.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= HUNT;
      expected <= '0;
    end else begin
      state    <= state_next;
      expected <= expected_next;
    end
  end

  // Next-state logic plus per-sample event classification.
  always_comb begin
    state_next    = state;
    expected_next = expected;
    violation     = 1'b0;
    round_hit     = 1'b0;
    if (in_valid) begin
      if (state == HUNT) begin
        if (phase_in == 2'd0) begin
          state_next    = LOCK;
          expected_next = 2'd1;
        end else if (phase_in == 2'd3) begin
          violation = 1'b1;
        end
      end else begin
        if (hold) begin
          state_next = LOCK;
        end else if (phase_in == expected) begin
          expected_next = succ(phase_in);
          round_hit     = (phase_in == 2'd0);
        end else if (phase_in == 2'd0) begin
          violation     = 1'b1;
          expected_next = 2'd1;
        end else begin
          violation     = 1'b1;
          state_next    = HUNT;
          expected_next = '0;
        end
      end
    end
  end

  // Output next-values: decode, round counting and error bookkeeping.
  always_comb begin
    oh_next         = phase_oh;
    round_done_next = round_hit;
    round_cnt_next  = round_hit ? round_cnt + 1'b1 : round_cnt;
    err_next        = err;
    err_cnt_next    = err_cnt;
    if (in_valid && !hold) begin
      case (phase_in)
        2'd0:    oh_next = 3'b001;
        2'd1:    oh_next = 3'b010;
        2'd2:    oh_next = 3'b100;
        default: oh_next = 3'b000;
      endcase
    end
    // A violation in the clearing cycle restarts the count at one.
    if (violation) begin
      err_next = 1'b1;
      if (clr_err)             err_cnt_next = {{(ERR_W-1){1'b0}}, 1'b1};
      else if (err_cnt != '1)  err_cnt_next = err_cnt + 1'b1;
    end else if (clr_err) begin
      err_next     = 1'b0;
      err_cnt_next = '0;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      phase_oh   <= '0;
      round_done <= 1'b0;
      round_cnt  <= '0;
      err        <= 1'b0;
      err_cnt    <= '0;
    end else begin
      phase_oh   <= oh_next;
      round_done <= round_done_next;
      round_cnt  <= round_cnt_next;
      err        <= err_next;
      err_cnt    <= err_cnt_next;
    end
  end

  assign locked = (state == LOCK);

endmodule
